// File: rtl/mul4_seq_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
//   start   : request, sampled only while the multiplier is idle
//   a, b    : multiplicand / multiplier, latched on an accepted start
//   busy    : high while an operation is in flight or completing
//   done    : one-cycle pulse, product valid
//   product : a*b, held until the next accepted start
interface mul4_seq_if #(
   parameter int unsigned WIDTH = 4
);
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   // Requester side
   modport master (
      output start, a, b,
      input  busy, done, product
   );

   // Multiplier side
   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/mul4_seq.sv
// Sequential shift-and-add unsigned multiplier.
// Accepts operands on a start pulse while idle, iterates WIDTH times, then
// presents a 2*WIDTH-bit product with a one-cycle done pulse. The product is
// held until the next accepted start.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : mul4_seq_if slave modport (start, a, b in; busy, done, product out)
module mul4_seq #(
   parameter int unsigned WIDTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   mul4_seq_if.slave  bus
);

   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mplr;
   logic [CNT_W-1:0] r_cnt;
   logic [PW-1:0]    r_product;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH-1:0] w_addend;
   logic [WIDTH:0]   w_sum;
   logic [PW-1:0]    w_shifted;

   // Partial-product add; the carry lands in the MSB of acc after the shift.
   assign w_addend  = r_mplr[0] ? r_mcand : '0;
   assign w_sum     = {1'b0, r_acc} + {1'b0, w_addend};
   assign w_shifted = {w_sum, r_mplr[WIDTH-1:1]};

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_mcand   <= '0;
         r_acc     <= '0;
         r_mplr    <= '0;
         r_cnt     <= '0;
         r_product <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mcand <= bus.a;
                  r_acc   <= '0;
                  r_mplr  <= bus.b;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc  <= w_shifted[PW-1:WIDTH];
               r_mplr <= w_shifted[WIDTH-1:0];
               r_cnt  <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_LAST) begin
                  r_product <= w_shifted;
                  r_done    <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.product = r_product;

endmodule

// File: tb/tb_mul4_seq.sv
// Self-checking bench for mul4_seq: directed cases plus exhaustive operand sweep
// against a plain a*b reference with the documented WIDTH-edge latency.
module tb_mul4_seq;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned PW    = 2 * WIDTH;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;
   int   cyc;

   mul4_seq_if #(.WIDTH(WIDTH)) bus ();

   mul4_seq #(.WIDTH(WIDTH)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation, wait for done with a bound, check latency and result,
   // then check done drops and the product is held through a few idle cycles.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
      logic [PW-1:0] exp_p;
      int lat;
      int idle;
      exp_p = PW'(a) * PW'(b);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      lat = 0;
      while (!bus.done && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
      check({tag, "_product"}, 32'(bus.product), 32'(exp_p));
      tick();
      check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
      check({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
      idle = int'($urandom_range(0, 2));
      for (int i = 0; i < idle; i++) tick();
      check({tag, "_held"}, 32'(bus.product), 32'(exp_p));
   endtask

   // Count done pulses over n cycles with start held low.
   task automatic count_done(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.done) pulses++;
      end
   endtask

   initial begin
      int pulses;
      int lat;
      int t_first;
      int t_second;
      n_checks  = 0;
      n_pass    = 0;
      cyc       = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Reset state
      tick();
      tick();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_product", 32'(bus.product), 32'd0);
      reset = 1'b0;
      tick();

      // Directed products
      run_op(4'h7, 4'h3, "t1_7x3");
      run_op(4'hF, 4'hF, "t2_FxF");
      run_op(4'h0, 4'hA, "t2_0xA");
      run_op(4'h8, 4'h1, "t2_8x1");

      // Start while busy (RUN and DONE) is dropped
      bus.start = 1'b1; bus.a = 4'h5; bus.b = 4'h6;
      tick();
      bus.start = 1'b0;
      tick();
      bus.start = 1'b1; bus.a = 4'h2; bus.b = 4'h2;
      tick();
      bus.start = 1'b0;
      lat = 2;
      while (!bus.done && lat < 20) begin
         tick();
         lat++;
      end
      check("t3_latency", 32'(lat), 32'(WIDTH));
      check("t3_product", 32'(bus.product), 32'h1E);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("t3_busy_drop", 32'(bus.busy), 32'd0);
      count_done(10, pulses);
      check("t3_no_second_done", 32'(pulses), 32'd0);
      check("t3_held", 32'(bus.product), 32'h1E);

      // Reset during the second RUN cycle aborts
      bus.start = 1'b1; bus.a = 4'h9; bus.b = 4'h9;
      tick();
      bus.start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t4_busy", 32'(bus.busy), 32'd0);
      check("t4_done", 32'(bus.done), 32'd0);
      check("t4_product", 32'(bus.product), 32'd0);
      count_done(8, pulses);
      check("t4_no_done", 32'(pulses), 32'd0);
      run_op(4'h9, 4'h9, "t4_9x9");

      // start held high: back-to-back operations WIDTH+2 edges apart
      bus.start = 1'b1; bus.a = 4'h3; bus.b = 4'h4;
      tick();
      bus.a = 4'hC; bus.b = 4'h5;
      lat = 0;
      while (!bus.done && lat < 20) begin
         tick();
         lat++;
      end
      t_first = cyc;
      check("t5_first_product", 32'(bus.product), 32'h0C);
      tick();
      tick();
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 20) begin
         tick();
         lat++;
      end
      t_second = cyc;
      check("t5_gap", 32'(t_second - t_first), 32'(WIDTH + 2));
      check("t5_second_product", 32'(bus.product), 32'h3C);
      count_done(8, pulses);
      check("t5_no_third", 32'(pulses), 32'd0);

      // Exhaustive operand sweep
      for (int ia = 0; ia < (1 << WIDTH); ia++) begin
         for (int ib = 0; ib < (1 << WIDTH); ib++) begin
            run_op(WIDTH'(ia), WIDTH'(ib), "t6");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
